// File: rtl/floo_mcast_fork_pkg.sv
// -----------------------------------------------------------------------------
// floo_mcast_fork_pkg
// Shared types for the multicast fork stage:
//   - hdr_t / flit_t : default flit layout (header carries `last`)
//   - fork_state_e   : debug view of the implicit fork FSM
//   - PORT_*         : router port indices (Eject/North/East/South/West)
// -----------------------------------------------------------------------------
package floo_mcast_fork_pkg;

    typedef struct packed {
        logic       last;
        logic [3:0] dst;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [15:0] payload;
    } flit_t;

    // IDLE: no selected output has taken the current flit yet.
    // PARTIAL: some outputs have taken it, others are still outstanding.
    typedef enum logic {
        FORK_IDLE    = 1'b0,
        FORK_PARTIAL = 1'b1
    } fork_state_e;

    localparam int unsigned PORT_EJECT = 0;
    localparam int unsigned PORT_NORTH = 1;
    localparam int unsigned PORT_EAST  = 2;
    localparam int unsigned PORT_SOUTH = 3;
    localparam int unsigned PORT_WEST  = 4;

endpackage

// File: rtl/floo_mcast_fork.sv
// -----------------------------------------------------------------------------
// floo_mcast_fork
// Replicates one input flit to every output selected by a one-hot or
// multi-hot route selection. Each output has its own valid/ready handshake;
// the input is popped only once every selected output has accepted its copy.
// Unicast traffic passes through with zero added latency.
//
// Handshake semantics (input side and each output port): a transfer happens
// in a cycle where valid and ready are both high; valid, once raised, stays
// high with stable data until that transfer; ready may depend
// combinationally on valid.
//
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   valid_i/ready_o/channel_i/route_sel_i : input flit and its route
//   valid_o/ready_i/channel_o             : per-output replicated flit
//   drop_o         : pulse when a valid flit with empty route is discarded
//   mcast_cnt_o    : completed multi-hot flits (saturating)
//   dbg_sent_o     : outputs that already accepted the current flit
//   dbg_state_o    : IDLE / PARTIAL view of the fork
//
// Build option: define FLOO_MCAST_FORK_STATS_EN to instantiate the
// multicast counter; otherwise mcast_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module floo_mcast_fork
    import floo_mcast_fork_pkg::*;
#(
    parameter int unsigned NumRoutes = 5,
    parameter type         flit_t    = floo_mcast_fork_pkg::flit_t,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  flit_t                channel_i,
    input  logic [NumRoutes-1:0] route_sel_i,
    output logic [NumRoutes-1:0] valid_o,
    input  logic [NumRoutes-1:0] ready_i,
    output flit_t [NumRoutes-1:0] channel_o,
    output logic                 drop_o,
    output logic [CntWidth-1:0]  mcast_cnt_o,
    output logic [NumRoutes-1:0] dbg_sent_o,
    output fork_state_e          dbg_state_o
);

    logic [NumRoutes-1:0] sent_q;
    logic [NumRoutes-1:0] hs;
    logic                 done;

    // Ports that already took the flit are masked so each sees one copy.
    assign valid_o = {NumRoutes{valid_i}} & route_sel_i & ~sent_q;
    assign hs      = valid_o & ready_i;
    // Complete once no selected port remains outstanding after this cycle.
    // An empty selection completes immediately (the drop case).
    assign done    = valid_i & ((route_sel_i & ~(sent_q | hs)) == '0);
    assign ready_o = done;
    assign drop_o  = valid_i & (route_sel_i == '0);

    always_comb begin
        for (int i = 0; i < NumRoutes; i++) begin
            channel_o[i] = channel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sent_q <= '0;
        end else if (done) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_q | hs;
        end
    end

    assign dbg_sent_o  = sent_q;
    assign dbg_state_o = (sent_q == '0) ? FORK_IDLE : FORK_PARTIAL;

`ifdef FLOO_MCAST_FORK_STATS_EN
    logic [CntWidth-1:0] cnt_q;
    logic                is_mcast;

    assign is_mcast = ($countones(route_sel_i) > 1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (done && is_mcast && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
        end
    end

    assign mcast_cnt_o = cnt_q;
`else
    assign mcast_cnt_o = '0;
`endif

endmodule

// File: tb/tb_floo_mcast_fork.sv
// -----------------------------------------------------------------------------
// tb_floo_mcast_fork
// Directed and randomized stimulus for floo_mcast_fork. The reference keeps,
// per in-flight flit, the set of ports that have been served and derives the
// expected outputs from the replication rules; a per-port copy counter checks
// that each selected port receives exactly one copy of every flit.
// -----------------------------------------------------------------------------
module tb_floo_mcast_fork;
    import floo_mcast_fork_pkg::*;

    localparam int NR = 5;
    localparam int CW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic              valid_i = 1'b0;
    logic              ready_o;
    flit_t             channel_i = '0;
    logic [NR-1:0]     route_sel_i = '0;
    logic [NR-1:0]     valid_o;
    logic [NR-1:0]     ready_i = '0;
    flit_t [NR-1:0]    channel_o;
    logic              drop_o;
    logic [CW-1:0]     mcast_cnt_o;
    logic [NR-1:0]     dbg_sent_o;
    fork_state_e       dbg_state_o;

    floo_mcast_fork #(.NumRoutes(NR), .flit_t(flit_t), .CntWidth(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .channel_i   (channel_i),
        .route_sel_i (route_sel_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .channel_o   (channel_o),
        .drop_o      (drop_o),
        .mcast_cnt_o (mcast_cnt_o),
        .dbg_sent_o  (dbg_sent_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- reference state / scoreboard ----------------
    int     n_cmp  = 0;
    int     n_fail = 0;
    bit     served [NR];      // port already delivered the current flit
    int     copies [NR];      // observed handshakes per port for current flit
    longint exp_cnt = 0;      // completed multi-hot flits
    logic [20:0] exp_q[$];    // flits waiting to complete, in order

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_expected();
`ifdef FLOO_MCAST_FORK_STATS_EN
        if (exp_cnt > 64'(32'hFFFF_FFFF)) return '1;
        return CW'(exp_cnt);
`else
        return '0;
`endif
    endfunction

    task automatic clear_flit_state();
        for (int p = 0; p < NR; p++) begin
            served[p] = 1'b0;
            copies[p] = 0;
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, update reference at posedge.
    task automatic step(input bit v, input logic [NR-1:0] sel, input logic [NR-1:0] rdy,
                        input flit_t f, input string tag, output bit done);
        logic [NR-1:0] e_valid, e_sent;
        bit            outstanding;
        @(negedge clk);
        valid_i     = v;
        route_sel_i = sel;
        ready_i     = rdy;
        channel_i   = f;
        #1;
        // Expected behaviour from the replication rules.
        e_valid     = '0;
        e_sent      = '0;
        outstanding = 1'b0;
        for (int p = 0; p < NR; p++) begin
            e_sent[p] = served[p];
            if (v && sel[p] && !served[p]) e_valid[p] = 1'b1;
            if (sel[p] && !served[p] && !(e_valid[p] && rdy[p])) outstanding = 1'b1;
        end
        done = v && !outstanding;
        chk({tag, ".valid_o"}, 64'(valid_o), 64'(e_valid));
        chk({tag, ".ready_o"}, 64'(ready_o), 64'(done));
        chk({tag, ".drop_o"},  64'(drop_o),  64'(v && (sel == '0)));
        chk({tag, ".sent"},    64'(dbg_sent_o), 64'(e_sent));
        chk({tag, ".state"},   64'(dbg_state_o), 64'((e_sent != '0) ? FORK_PARTIAL : FORK_IDLE));
        chk({tag, ".cnt"},     64'(mcast_cnt_o), 64'(cnt_expected()));
        for (int p = 0; p < NR; p++) begin
            if (valid_o[p]) chk({tag, ".chan"}, 64'(channel_o[p]), 64'(f));
            if (valid_o[p] && ready_i[p]) copies[p]++;
        end
        @(posedge clk);
        if (done) begin
            for (int p = 0; p < NR; p++)
                if (sel[p]) chk({tag, ".copies"}, 64'(copies[p]), 64'd1);
            if ($countones(sel) > 1) exp_cnt++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            clear_flit_state();
        end else begin
            for (int p = 0; p < NR; p++)
                if (e_valid[p] && rdy[p]) served[p] = 1'b1;
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_ni  = 1'b0;
        ready_i = '0;
        repeat (cycles) @(posedge clk);
        clear_flit_state();
        exp_cnt = 0;
        exp_q.delete();
        @(negedge clk);
        chk("rst.sent", 64'(dbg_sent_o), 64'd0);
        chk("rst.cnt",  64'(mcast_cnt_o), 64'd0);
        rst_ni = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit    d;
        int    ndone;
        flit_t f;
        flit_t held;
        logic [NR-1:0] sel;

        clear_flit_state();
        // Reset with idle inputs.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.valid_o", 64'(valid_o), 64'd0);
        chk("reset.drop_o",  64'(drop_o), 64'd0);
        chk("reset.cnt",     64'(mcast_cnt_o), 64'd0);
        chk("reset.sent",    64'(dbg_sent_o), 64'd0);
        rst_ni = 1'b1;

        // Unicast: 8 back-to-back flits to East, all ready.
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            f = flit_t'($urandom());
            exp_q.push_back(f);
            step(1'b1, 5'b00100, 5'b11111, f, "unicast", d);
            if (d) ndone++;
        end
        chk("unicast.flits", 64'(ndone), 64'd8);

        // Multicast, all ready: completes in one cycle.
        f = flit_t'($urandom());
        step(1'b1, 5'b10110, 5'b11111, f, "mcast_all", d);
        chk("mcast_all.cnt_after", 64'(mcast_cnt_o), 64'(cnt_expected()));

        // Staggered acceptance.
        f = flit_t'($urandom());
        step(1'b1, 5'b00011, 5'b00001, f, "stagger0", d);
        step(1'b1, 5'b00011, 5'b00010, f, "stagger1", d);

        // Backpressure hold for 10 cycles, then release.
        f = flit_t'($urandom());
        repeat (10) step(1'b1, 5'b11000, 5'b00000, f, "hold", d);
        step(1'b1, 5'b11000, 5'b11000, f, "hold_rel", d);

        // Drop of an empty route.
        f = flit_t'($urandom());
        step(1'b1, 5'b00000, 5'b11111, f, "drop", d);
        step(1'b0, 5'b00000, 5'b11111, f, "drop_idle", d);

        // Reset mid-PARTIAL: port 0 served, then reset; flit re-offered.
        f = flit_t'($urandom());
        step(1'b1, 5'b00011, 5'b00001, f, "rstmid0", d);
        apply_reset(2);
        step(1'b1, 5'b00011, 5'b00000, f, "rstmid_reoffer", d);
        step(1'b1, 5'b00011, 5'b00011, f, "rstmid_done", d);

        // Randomized traffic: route held until the flit completes.
        for (int n = 0; n < 300; n++) begin
            int r;
            int cyc;
            r = $urandom_range(0, 9);
            if (r == 0)      sel = '0;
            else if (r <= 4) sel = NR'(1) << $urandom_range(0, NR - 1);
            else             sel = NR'($urandom_range(1, (1 << NR) - 1));
            held = flit_t'($urandom());
            exp_q.push_back(held);
            if ($urandom_range(0, 3) == 0) step(1'b0, NR'($urandom()), NR'($urandom()), flit_t'($urandom()), "rnd_idle", d);
            d = 1'b0;
            cyc = 0;
            while (!d && cyc < 64) begin
                logic [NR-1:0] rdy;
                rdy = (cyc >= 32) ? '1 : NR'($urandom());
                step(1'b1, sel, rdy, held, "rnd", d);
                cyc++;
            end
            n_cmp++;
            if (!d) begin
                n_fail++;
                $error("FAIL rnd.timeout: observed incomplete after %0d cycles expected completion", cyc);
            end
        end
        chk("final.queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
